cut_activity_probe: RTL and testbench

- Stimulus/response end of a combinational cut interface: drives N_IN-bit input vectors into a cut (an ABC-written sub-circuit) and samples its single output.
- Builds the cut's truth table and per-run switching-activity counts used for power characterization of rewritten sub-circuits.
- Sits in the power-experiment harness, one instance per cut under test.

---
 rtl/cut_probe_pkg.sv | 27 ++
 rtl/cut_probe_lfsr.sv | 34 +++
 rtl/cut_activity_probe.sv | 154 +++++++++++++++
 tb/tb_cut_activity_probe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cut_probe_pkg.sv
// Shared types and helpers for the cut activity probe: FSM states, LFSR constants
// and a saturating adder used by all activity counters.
package cut_probe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } probe_state_e;

    // Fibonacci taps 16,14,13,11 expressed as state bits 0,2,3,5 for a right-shifting register
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] effective_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/cut_probe_lfsr.sv
// 16-bit Fibonacci LFSR with load/step controls; exposes the low bits of the
// state it will move to on the next step.
module cut_probe_lfsr
    import cut_probe_pkg::*;
#(
    parameter int          OUT_W = 4,
    parameter logic [15:0] SEED  = LFSR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] next_low
);

    localparam logic [15:0] EFF_SEED = effective_seed(SEED);

    logic [15:0] state;
    logic [15:0] next_state;

    assign next_state = {^(state & LFSR_TAPS), state[15:1]};
    assign next_low   = next_state[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EFF_SEED;
        end else if (load) begin
            state <= EFF_SEED;
        end else if (step) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/cut_activity_probe.sv
// Drives vectors into a combinational cut, records its truth table and switching activity.
// Optional golden-table comparison is enabled by defining CUT_PROBE_GOLDEN_CHECK_EN.
module cut_activity_probe
    import cut_probe_pkg::*;
#(
    parameter int          N_IN      = 4,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     num_vec,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN-1:0]      cut_in,
    input  logic                 cut_out,
    output logic [2**N_IN-1:0]   truth_tbl,
    output logic [CNT_W-1:0]     in_toggles,
    output logic [CNT_W-1:0]     out_toggles,
    output logic [CNT_W-1:0]     ones_cnt
`ifdef CUT_PROBE_GOLDEN_CHECK_EN
    ,
    input  logic [2**N_IN-1:0]   golden_tt,
    output logic                 mismatch,
    output logic [N_IN-1:0]      mismatch_idx
`endif
);

    localparam int          NV       = 2**N_IN;
    localparam int          REM_W    = (CNT_W > N_IN) ? CNT_W + 1 : N_IN + 2;
    localparam logic [31:0] CNT_MAX  = 32'((64'(1) << CNT_W) - 64'(1));
    localparam logic [15:0] EFF_SEED = effective_seed(LFSR_SEED);

    probe_state_e       state;
    probe_state_e       state_nxt;
    logic [REM_W-1:0]   remaining;
    logic [REM_W-1:0]   vec_total;
    logic               mode_r;
    logic               first_sample;
    logic               prev_out;
    logic               accept;
    logic               last_sample;
    logic               advance;
    logic [N_IN-1:0]    lfsr_next;
    logic [N_IN-1:0]    next_vec;

    assign accept      = (state == IDLE) && start;
    assign vec_total   = mode ? REM_W'(num_vec) : REM_W'(NV);
    assign last_sample = (state == RUN) && (remaining == REM_W'(1));
    assign advance     = (state == RUN) && !last_sample;
    assign next_vec    = mode_r ? lfsr_next : cut_in + N_IN'(1);

    cut_probe_lfsr #(
        .OUT_W (N_IN),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (advance && mode_r),
        .next_low (lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (vec_total == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_sample) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every RUN edge samples the current vector; only non-final samples move to the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            cut_in       <= '0;
            truth_tbl    <= '0;
            in_toggles   <= '0;
            out_toggles  <= '0;
            ones_cnt     <= '0;
            remaining    <= '0;
            mode_r       <= 1'b0;
            first_sample <= 1'b1;
            prev_out     <= 1'b0;
        end else if (accept) begin
            truth_tbl    <= '0;
            in_toggles   <= '0;
            out_toggles  <= '0;
            ones_cnt     <= '0;
            remaining    <= vec_total;
            mode_r       <= mode;
            first_sample <= 1'b1;
            prev_out     <= 1'b0;
            if (vec_total != '0) begin
                cut_in <= mode ? EFF_SEED[N_IN-1:0] : '0;
            end
        end else if (state == RUN) begin
            truth_tbl[cut_in] <= cut_out;
            ones_cnt          <= CNT_W'(sat_add(32'(ones_cnt), 32'(cut_out), CNT_MAX));
            if (!first_sample && (cut_out != prev_out)) begin
                out_toggles <= CNT_W'(sat_add(32'(out_toggles), 32'd1, CNT_MAX));
            end
            prev_out     <= cut_out;
            first_sample <= 1'b0;
            remaining    <= remaining - REM_W'(1);
            if (advance) begin
                cut_in     <= next_vec;
                in_toggles <= CNT_W'(sat_add(32'(in_toggles),
                                             32'($countones(cut_in ^ next_vec)), CNT_MAX));
            end
        end
    end

`ifdef CUT_PROBE_GOLDEN_CHECK_EN
    // Sticky flag; the index is frozen at the first disagreeing vector of the run
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
        end else if ((state == RUN) && (cut_out != golden_tt[cut_in])) begin
            mismatch <= 1'b1;
            if (!mismatch) begin
                mismatch_idx <= cut_in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cut_activity_probe.sv
// Self-checking bench for cut_activity_probe: per-cycle comparison against a run-level
// model built from the vector list and cut responses, plus hand-computed literal checks.
module tb_cut_activity_probe;

    localparam int N_IN  = 4;
    localparam int CNT_W = 16;
    localparam int NV    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [CNT_W-1:0]  num_vec = '0;
    logic              busy, done, cut_out;
    logic [N_IN-1:0]   cut_in;
    logic [NV-1:0]     truth_tbl;
    logic [CNT_W-1:0]  in_toggles, out_toggles, ones_cnt;
    int                cut_sel = 0;

    logic              start_sat = 1'b0;
    logic              mode_sat = 1'b0;
    logic [3:0]        num_vec_sat = '0;
    logic              busy_sat, done_sat;
    logic [N_IN-1:0]   cut_in_sat;
    logic [NV-1:0]     truth_tbl_sat;
    logic [3:0]        in_toggles_sat, out_toggles_sat, ones_cnt_sat;

    int checks = 0;
    int errors = 0;

`ifdef CUT_PROBE_GOLDEN_CHECK_EN
    logic [NV-1:0]     golden_tt = 16'h8000;
    logic              mismatch;
    logic [N_IN-1:0]   mismatch_idx;
`endif

    always #5 clk = ~clk;

    function automatic logic cut_fn(input int sel, input logic [3:0] v);
        case (sel)
            0:       return &v;
            1:       return ^v;
            2:       return 1'b0;
            3:       return v[0];
            4:       return |v;
            default: return 1'b1;
        endcase
    endfunction

    assign cut_out = cut_fn(cut_sel, cut_in);

    cut_activity_probe #(.N_IN(N_IN), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .num_vec     (num_vec),
        .busy        (busy),
        .done        (done),
        .cut_in      (cut_in),
        .cut_out     (cut_out),
        .truth_tbl   (truth_tbl),
        .in_toggles  (in_toggles),
        .out_toggles (out_toggles),
        .ones_cnt    (ones_cnt)
`ifdef CUT_PROBE_GOLDEN_CHECK_EN
        ,
        .golden_tt    (golden_tt),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx)
`endif
    );

    // Narrow-counter instance with a constant-1 cut, used to reach saturation quickly
    cut_activity_probe #(.N_IN(N_IN), .CNT_W(4), .LFSR_SEED(16'hACE1)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .start       (start_sat),
        .mode        (mode_sat),
        .num_vec     (num_vec_sat),
        .busy        (busy_sat),
        .done        (done_sat),
        .cut_in      (cut_in_sat),
        .cut_out     (1'b1),
        .truth_tbl   (truth_tbl_sat),
        .in_toggles  (in_toggles_sat),
        .out_toggles (out_toggles_sat),
        .ones_cnt    (ones_cnt_sat)
`ifdef CUT_PROBE_GOLDEN_CHECK_EN
        ,
        .golden_tt    (16'hFFFF),
        .mismatch     (),
        .mismatch_idx ()
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- run-level model ----------------
    logic [3:0] m_vec[$];
    logic       m_resp[$];
    int         m_V = 0;
    int         m_e = 0;
    bit         m_active = 0;
    bit         model_valid = 0;
    logic [3:0] m_prev_cut = '0;

    function automatic logic [15:0] lfsr_model_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [3:0] expCut();
        if (!m_active) return 4'h0;
        if (m_V == 0) return m_prev_cut;
        return m_vec[(m_e < m_V - 1) ? m_e : m_V - 1];
    endfunction

    always @(posedge clk) begin
        bit         idle;
        logic [15:0] s;
        if (rst) begin
            m_active    = 0;
            m_V         = 0;
            m_e         = 0;
            model_valid = 1;
            m_vec.delete();
            m_resp.delete();
        end else begin
            idle = !m_active || (m_e >= m_V + 1);
            if (m_active) m_e++;
            if (idle && start) begin
                m_prev_cut = expCut();
                m_vec.delete();
                m_resp.delete();
                if (mode) begin
                    m_V = int'(num_vec);
                    s   = 16'hACE1;
                    for (int i = 0; i < m_V; i++) begin
                        m_vec.push_back(s[3:0]);
                        s = lfsr_model_step(s);
                    end
                end else begin
                    m_V = NV;
                    for (int i = 0; i < NV; i++) m_vec.push_back(4'(i));
                end
                foreach (m_vec[i]) m_resp.push_back(cut_fn(cut_sel, m_vec[i]));
                m_active = 1;
                m_e      = 0;
            end
        end
    end

    // Single compare process: every cycle after the first reset edge
    always @(negedge clk) begin
        int         s_cnt, adv, e_ones, e_outt, e_int;
        logic [NV-1:0] e_tt;
        if (model_valid) begin
            s_cnt  = !m_active ? 0 : ((m_e < m_V) ? m_e : m_V);
            adv    = (s_cnt == 0) ? 0 : ((s_cnt < m_V) ? s_cnt : m_V - 1);
            e_tt   = '0;
            e_ones = 0;
            e_outt = 0;
            e_int  = 0;
            for (int i = 0; i < s_cnt; i++) begin
                e_tt[m_vec[i]] = m_resp[i];
                e_ones += int'(m_resp[i]);
                if (i > 0 && m_resp[i] != m_resp[i-1]) e_outt++;
            end
            for (int i = 0; i < adv; i++) e_int += $countones(m_vec[i] ^ m_vec[i+1]);
            checkOutput("busy", busy, m_active && (m_e < m_V));
            checkOutput("done", done, m_active && (m_e == m_V));
            checkOutput("cut_in", cut_in, expCut());
            checkOutput("truth_tbl", truth_tbl, e_tt);
            checkOutput("ones_cnt", ones_cnt, (e_ones > 65535) ? 65535 : e_ones);
            checkOutput("out_toggles", out_toggles, (e_outt > 65535) ? 65535 : e_outt);
            checkOutput("in_toggles", in_toggles, (e_int > 65535) ? 65535 : e_int);
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input bit m, input logic [CNT_W-1:0] nv, input int sel,
                                 input bit with_sat);
        @(posedge clk);
        #1;
        mode      = m;
        num_vec   = nv;
        cut_sel   = sel;
        start     = 1'b1;
        start_sat = with_sat;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = -1;
        for (int d = 1; d <= limit; d++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_at = d;
                break;
            end
        end
        if (done_at < 0) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_n, done_at, seen;
        logic [NV-1:0]    r_tt;
        logic [CNT_W-1:0] r_ones, r_in, r_out;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cut_in", cut_in, 0);
        checkOutput("reset_truth_tbl", truth_tbl, 0);

        $display("[TB] exhaustive AND");
        applyStimulus(1'b0, '0, 0, 1'b1);
        waitDone(40, busy_n, done_at);
        checkOutput("and_busy_cycles", busy_n, 16);
        checkOutput("and_done_cycle", done_at, 17);
        checkOutput("and_truth_tbl", truth_tbl, 16'h8000);
        checkOutput("and_ones_cnt", ones_cnt, 1);
        checkOutput("and_out_toggles", out_toggles, 1);
        checkOutput("and_in_toggles", in_toggles, 26);
        checkOutput("sat_ones_cnt", ones_cnt_sat, 15);
        checkOutput("sat_in_toggles", in_toggles_sat, 15);
        checkOutput("sat_out_toggles", out_toggles_sat, 0);
        checkOutput("sat_truth_tbl", truth_tbl_sat, 16'hFFFF);
`ifdef CUT_PROBE_GOLDEN_CHECK_EN
        checkOutput("and_mismatch", mismatch, 0);
`endif

        $display("[TB] exhaustive XOR");
        applyStimulus(1'b0, '0, 1, 1'b0);
        waitDone(40, busy_n, done_at);
        checkOutput("xor_truth_tbl", truth_tbl, 16'h6996);
        checkOutput("xor_ones_cnt", ones_cnt, 8);
        checkOutput("xor_out_toggles", out_toggles, 10);
        checkOutput("xor_in_toggles", in_toggles, 26);

        $display("[TB] random num_vec=0");
        applyStimulus(1'b1, 16'd0, 2, 1'b0);
        waitDone(10, busy_n, done_at);
        checkOutput("zero_busy_cycles", busy_n, 0);
        checkOutput("zero_done_cycle", done_at, 1);
        checkOutput("zero_truth_tbl", truth_tbl, 0);
        checkOutput("zero_counters", {ones_cnt, in_toggles, out_toggles}, 0);

        $display("[TB] random num_vec=5, buffer cut");
        applyStimulus(1'b1, 16'd5, 3, 1'b0);
        waitDone(20, busy_n, done_at);
        checkOutput("rnd_busy_cycles", busy_n, 5);
        checkOutput("rnd_truth_tbl", truth_tbl, 16'h0002);
        checkOutput("rnd_ones_cnt", ones_cnt, 1);
        checkOutput("rnd_out_toggles", out_toggles, 1);
        checkOutput("rnd_in_toggles", in_toggles, 4);
        checkOutput("rnd_last_cut_in", cut_in, 4'hE);
        r_tt = truth_tbl; r_ones = ones_cnt; r_in = in_toggles; r_out = out_toggles;
        applyStimulus(1'b1, 16'd5, 3, 1'b0);
        waitDone(20, busy_n, done_at);
        checkOutput("rerun_truth_tbl", truth_tbl, r_tt);
        checkOutput("rerun_counters", {ones_cnt, in_toggles, out_toggles}, {r_ones, r_in, r_out});

`ifdef CUT_PROBE_GOLDEN_CHECK_EN
        $display("[TB] golden check with OR cut");
        applyStimulus(1'b0, '0, 4, 1'b0);
        waitDone(40, busy_n, done_at);
        checkOutput("gold_mismatch", mismatch, 1);
        checkOutput("gold_mismatch_idx", mismatch_idx, 1);
`endif

        $display("[TB] ignored start then reset mid-run");
        applyStimulus(1'b0, '0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cut_in == 4'd7) seen = 1;
        end
        checkOutput("reached_vector7", seen, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checkOutput("abort_no_done", seen, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cut_in", cut_in, 0);
        checkOutput("abort_counters", {ones_cnt, in_toggles, out_toggles}, 0);
        checkOutput("abort_truth_tbl", truth_tbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
